cacheline_adapter: RTL and testbench

- Sits directly downstream of the cache controller's DFP port.
- Converts a single full-line DFP read or write (LINE_WIDTH bits, one request/response handshake) into a fixed-length burst on the burst-memory (bmem) interface, BURST_WIDTH bits per beat.
- Assembles read beats into a line and serialises write lines into beats.
- Returns a single-cycle dfp_resp when the transaction completes.

---
 rtl/cacheline_adapter_if.sv | 68 ++++++
 rtl/cacheline_adapter.sv | 196 +++++++++++++++++++
 tb/tb_cacheline_adapter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// -----------------------------------------------------------------------------
// cacheline_adapter_if
//
// Purpose: bundles the two buses seen by the cache-line adapter.
//   - DFP side: one full-line read/write request from the cache controller,
//     answered with a single-cycle completion pulse.
//   - bmem side: burst memory, BURST_WIDTH bits per beat.
//
// Signals:
//   dfp_addr    [ADDR_WIDTH]  line address from cache (byte address)
//   dfp_read                  line read request, held until dfp_resp
//   dfp_write                 line write request, held until dfp_resp
//   dfp_wdata   [LINE_WIDTH]  line to write
//   dfp_rdata   [LINE_WIDTH]  assembled read line
//   dfp_resp                  one-cycle completion pulse
//   bmem_addr   [ADDR_WIDTH]  line-aligned burst address
//   bmem_read                 read burst command
//   bmem_write                write beat valid
//   bmem_wdata  [BURST_WIDTH] write beat data
//   bmem_ready                memory can accept a new command
//   bmem_raddr  [ADDR_WIDTH]  address tag of returning read beats
//   bmem_rdata  [BURST_WIDTH] read beat data
//   bmem_rvalid               read beat valid
//   addr_err                  sticky returned-address mismatch flag
//
// Modports:
//   slave  - the adapter's view (consumes requests and memory responses)
//   master - the environment's view (cache controller plus burst memory)
// -----------------------------------------------------------------------------
interface cacheline_adapter_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]  dfp_addr;
    logic                   dfp_read;
    logic                   dfp_write;
    logic [LINE_WIDTH-1:0]  dfp_wdata;
    logic [LINE_WIDTH-1:0]  dfp_rdata;
    logic                   dfp_resp;

    logic [ADDR_WIDTH-1:0]  bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BURST_WIDTH-1:0] bmem_wdata;
    logic                   bmem_ready;
    logic [ADDR_WIDTH-1:0]  bmem_raddr;
    logic [BURST_WIDTH-1:0] bmem_rdata;
    logic                   bmem_rvalid;

    logic                   addr_err;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output addr_err
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  addr_err
    );
endinterface

// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
//
// Purpose: turns one full-line DFP read or write from the cache controller
// into a fixed-length burst of BEATS = LINE_WIDTH/BURST_WIDTH beats on the
// burst-memory interface. Read beats are assembled into a line; write lines
// are serialised into beats. Completion is a single-cycle dfp_resp.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - cacheline_adapter_if.slave (DFP request side + bmem burst side)
//
// Optional feature (macro CACHELINE_ADAPTER_RADDR_CHECK_EN):
//   defined   - read beats whose bmem_raddr differs from the latched line
//               address are dropped and set the sticky addr_err flag.
//   undefined - bmem_raddr is ignored and addr_err is constant 0.
// -----------------------------------------------------------------------------
module cacheline_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input logic                clk,
    input logic                rst,
    cacheline_adapter_if.slave bus
);
    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEAT,
        WR_BEAT,
        RESP
    } state_t;

    // A line viewed as an array of beats, so beat k is simply line[k].
    typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    line_t                 r_line;      // write line being sent, or read line being assembled
    line_t                 r_rdata;     // last completed read line
    logic                  r_addr_err;

    logic [ADDR_WIDTH-1:0] w_line_addr;
    logic                  w_beat_in;   // read beat accepted this cycle
    logic                  w_beat_out;  // write beat issued this cycle
    logic                  w_raddr_bad;
    line_t                 w_line_asm;
    logic                  w_unused_offset;

    assign w_line_addr     = {bus.dfp_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign w_unused_offset = ^bus.dfp_addr[OFFSET_W-1:0];

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    assign w_raddr_bad = (bus.bmem_raddr != r_addr);
`else
    logic w_unused_raddr;
    assign w_raddr_bad    = 1'b0;
    assign w_unused_raddr = ^bus.bmem_raddr;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_beat_in      = 1'b0;
        w_beat_out     = 1'b0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.dfp_resp   = 1'b0;

        case (r_state)
            IDLE: begin
                // Write wins so a dirty victim is written back before the fill.
                if (bus.dfp_write) begin
                    w_state_next = WR_BEAT;
                end else if (bus.dfp_read) begin
                    w_state_next = RD_CMD;
                end
            end

            RD_CMD: begin
                bus.bmem_read = 1'b1;
                if (bus.bmem_ready) begin
                    w_state_next = RD_BEAT;
                end
            end

            RD_BEAT: begin
                w_beat_in = bus.bmem_rvalid && !w_raddr_bad;
                if (w_beat_in && (r_cnt == LAST_BEAT)) begin
                    w_state_next = RESP;
                end
            end

            WR_BEAT: begin
                // Only the first beat waits for ready; once the burst has
                // started the remaining beats go out back to back.
                w_beat_out     = bus.bmem_ready || (r_cnt != '0);
                bus.bmem_write = w_beat_out;
                if (w_beat_out && (r_cnt == LAST_BEAT)) begin
                    w_state_next = RESP;
                end
            end

            RESP: begin
                bus.dfp_resp = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line with the incoming beat merged into slot r_cnt.
    always_comb begin
        w_line_asm        = r_line;
        w_line_asm[r_cnt] = bus.bmem_rdata;
    end

    // -------------------------------------------------------------------------
    // Datapath: address latch, line buffer, beat counter, error flag
    // -------------------------------------------------------------------------
    // NOTE: the line buffers are reset (not left uninitialised like a RAM)
    // because they drive dfp_rdata/bmem_wdata directly and those must read 0
    // out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_line     <= '0;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if ((r_state == IDLE) && (bus.dfp_write || bus.dfp_read)) begin
                r_addr <= w_line_addr;
            end

            if ((r_state == IDLE) && bus.dfp_write) begin
                r_line <= bus.dfp_wdata;
            end

            if (w_beat_in) begin
                r_line <= w_line_asm;
                if (r_cnt == LAST_BEAT) begin
                    r_rdata <= w_line_asm;
                end
            end

            // The counter is back at 0 after the last beat, so the next
            // transaction always starts from slot 0.
            if (w_beat_in || w_beat_out) begin
                r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + 1'b1;
            end

            if ((r_state == RD_BEAT) && bus.bmem_rvalid && w_raddr_bad) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    assign bus.bmem_addr  = r_addr;
    assign bus.bmem_wdata = (r_state == WR_BEAT) ? r_line[r_cnt] : '0;
    assign bus.dfp_rdata  = r_rdata;
    assign bus.addr_err   = r_addr_err;

endmodule

// File: tb/tb_cacheline_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adapter
//
// Self-checking bench for cacheline_adapter. A table of line transactions is
// driven one after another; expected command addresses, write beats and
// completion data are queued when a transaction is launched and compared by a
// monitor when the DUT produces them. Hand-written sequences cover
// writeback-then-fetch, asynchronous reset mid-burst and the optional
// returned-address check (macro CACHELINE_ADAPTER_RADDR_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_cacheline_adapter;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [LW-1:0] line_t;

    typedef struct {
        logic          is_write;
        logic [AW-1:0] addr;
        line_t         data;
        int            ready_delay;
        int            latency;
        logic [15:0]   valid_pat;
        logic [AW-1:0] exp_baddr;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    cacheline_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] q_cmd[$];
    beat_t         q_wbeat[$];
    line_t         q_resp[$];
    int            n_cmd   = 0;
    int            n_wbeat = 0;
    int            n_resp  = 0;
    int            n_rd_hi = 0;
    line_t         last_line;
    vec_t          vecs[5];

    task automatic check(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b1;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
    endtask

    // Scoreboard side: compare every DUT-produced event against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bmem_read) n_rd_hi++;
            if (bus.bmem_read && bus.bmem_ready) begin
                n_cmd++;
                check("cmd_expected", line_t'(q_cmd.size() != 0), 1);
                if (q_cmd.size() != 0) check("cmd_addr", bus.bmem_addr, q_cmd.pop_front());
            end
            if (bus.bmem_write) begin
                n_wbeat++;
                check("wbeat_expected", line_t'(q_wbeat.size() != 0), 1);
                if (q_wbeat.size() != 0) begin
                    beat_t b;
                    b = q_wbeat.pop_front();
                    check("wbeat_addr", bus.bmem_addr, b.addr);
                    check("wbeat_data", bus.bmem_wdata, b.data);
                end
            end
            if (bus.dfp_resp) begin
                n_resp++;
                check("resp_expected", line_t'(q_resp.size() != 0), 1);
                if (q_resp.size() != 0) check("resp_rdata", bus.dfp_rdata, q_resp.pop_front());
            end
        end
    end

    // Starts and ends one cycle after a posedge with the DUT in IDLE.
    // bad_pat marks beat cycles carrying a wrong bmem_raddr.
    task automatic run_read(input logic [AW-1:0] addr, input line_t data,
                            input int ready_delay, input int latency,
                            input logic [15:0] vpat, input logic [15:0] bad_pat,
                            input logic [AW-1:0] exp_baddr);
        int k;
        int rd_hi0;
        int resp0;
        rd_hi0 = n_rd_hi;
        resp0  = n_resp;
        q_cmd.push_back(exp_baddr);
        q_resp.push_back(data);
        last_line = data;

        bus.dfp_addr    = addr;
        bus.dfp_read    = 1'b1;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        step();                        // RD_CMD
        bus.dfp_addr = ~addr;          // must be ignored after the latch
        for (int i = 0; i < ready_delay; i++) step();
        bus.bmem_ready = 1'b1;
        step();                        // command accepted
        for (int i = 0; i < latency; i++) step();

        k = 0;
        for (int j = 0; j < 16 && k < NB; j++) begin
            bus.bmem_rvalid = vpat[j];
            bus.bmem_raddr  = bad_pat[j] ? (exp_baddr ^ 32'h0000_0100) : exp_baddr;
            bus.bmem_rdata  = (bad_pat[j] && CHK_EN) ? 64'hBAD0_BAD0_BAD0_BAD0 : data[k*BW +: BW];
            step();
            if (vpat[j] && !(bad_pat[j] && CHK_EN)) k++;
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        check("rd_resp_after_last_beat", bus.dfp_resp, 1);
        check("rd_cmd_cycles", n_rd_hi - rd_hi0, ready_delay + 1);
        step();                        // back in IDLE
        bus.dfp_read = 1'b0;
        check("rd_resp_count", n_resp - resp0, 1);
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input line_t data,
                             input int ready_delay, input logic [AW-1:0] exp_baddr);
        int wb0;
        int resp0;
        wb0   = n_wbeat;
        resp0 = n_resp;
        for (int k = 0; k < NB; k++) q_wbeat.push_back('{exp_baddr, data[k*BW +: BW]});
        q_resp.push_back(last_line);

        bus.dfp_addr   = addr;
        bus.dfp_wdata  = data;
        bus.dfp_write  = 1'b1;
        bus.bmem_ready = (ready_delay == 0);
        step();                        // WR_BEAT
        bus.dfp_addr  = ~addr;
        bus.dfp_wdata = ~data;
        for (int i = 0; i < ready_delay; i++) begin
            bus.bmem_ready = 1'b0;
            #1;
            check("wr_no_beat_while_not_ready", bus.bmem_write, 0);
            step();
        end
        bus.bmem_ready = 1'b1;
        #1;
        check("wr_first_beat", bus.bmem_write, 1);
        step();
        for (int k = 1; k < NB; k++) begin
            bus.bmem_ready = 1'b0;     // later beats ignore ready
            #1;
            check("wr_burst_beat", bus.bmem_write, 1);
            step();
        end
        check("wr_resp_after_last_beat", bus.dfp_resp, 1);
        check("wr_beat_count", n_wbeat - wb0, NB);
        step();
        bus.dfp_write  = 1'b0;
        bus.bmem_ready = 1'b1;
        check("wr_resp_count", n_resp - resp0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int cmd0;
        int wb0;
        int resp0;
        int rd0;

        vecs[0] = '{1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    0, 2, 16'h000F, 32'h0000_1220};
        vecs[1] = '{1'b1, 32'h0000_56A8,
                    {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                     64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
                    5, 0, 16'h0000, 32'h0000_56A0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hA5A5_5A5A_F00F_0FF0, 64'h1357_9BDF_2468_ACE0},
                    2, 0, 16'h0059, 32'hFFFF_FFE0};
        vecs[3] = '{1'b1, 32'h0000_001F,
                    {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000},
                    0, 0, 16'h0000, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h8000_0040,
                    {64'hCAFE_F00D_0000_0004, 64'hCAFE_F00D_0000_0003,
                     64'hCAFE_F00D_0000_0002, 64'hCAFE_F00D_0000_0001},
                    1, 5, 16'h0055, 32'h8000_0040};

        idle_inputs();
        last_line = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_dfp_resp",   bus.dfp_resp,   0);
        check("rst_bmem_read",  bus.bmem_read,  0);
        check("rst_bmem_write", bus.bmem_write, 0);
        check("rst_bmem_addr",  bus.bmem_addr,  0);
        check("rst_bmem_wdata", bus.bmem_wdata, 0);
        check("rst_dfp_rdata",  bus.dfp_rdata,  0);
        check("rst_addr_err",   bus.addr_err,   0);
        step();
        rst = 1'b0;
        step();

        // Table-driven transactions, back to back.
        foreach (vecs[i]) begin
            if (vecs[i].is_write)
                run_write(vecs[i].addr, vecs[i].data, vecs[i].ready_delay, vecs[i].exp_baddr);
            else
                run_read(vecs[i].addr, vecs[i].data, vecs[i].ready_delay, vecs[i].latency,
                         vecs[i].valid_pat, 16'h0000, vecs[i].exp_baddr);
        end

        // Writeback then fetch: read raised the cycle after the write's resp.
        cmd0 = n_cmd; wb0 = n_wbeat; resp0 = n_resp;
        run_write(32'h0000_3004, {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
                                  64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000},
                  0, 32'h0000_3000);
        run_read(32'h0000_3010, {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
                                 64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000},
                 0, 1, 16'h000F, 16'h0000, 32'h0000_3000);
        for (int i = 0; i < 4; i++) step();
        check("wbf_cmd_count",   n_cmd - cmd0,   1);
        check("wbf_wbeat_count", n_wbeat - wb0,  NB);
        check("wbf_resp_count",  n_resp - resp0, 2);

        // Asynchronous reset after two beats of a read, then stray beats.
        q_cmd.push_back(32'h0000_4440);
        bus.dfp_addr = 32'h0000_4444;
        bus.dfp_read = 1'b1;
        step();
        step();
        bus.bmem_raddr = 32'h0000_4440;
        for (int i = 0; i < 2; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = 64'h5555_0000_0000_0000 | 64'(i);
            step();
        end
        bus.bmem_rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_bmem_addr",  bus.bmem_addr,  0);
        check("arst_dfp_rdata",  bus.dfp_rdata,  0);
        check("arst_bmem_read",  bus.bmem_read,  0);
        check("arst_bmem_write", bus.bmem_write, 0);
        check("arst_dfp_resp",   bus.dfp_resp,   0);
        last_line = '0;
        step();
        rst = 1'b0;
        bus.dfp_read = 1'b0;
        resp0 = n_resp; rd0 = n_rd_hi;
        for (int i = 0; i < 2; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            step();
        end
        bus.bmem_rvalid = 1'b0;
        step();
        check("stray_no_resp",   n_resp - resp0, 0);
        check("stray_no_cmd",    n_rd_hi - rd0,  0);
        check("stray_rdata",     bus.dfp_rdata,  0);
        run_read(32'h0000_6000, {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
                                 64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000},
                 0, 2, 16'h000F, 16'h0000, 32'h0000_6000);
        check("post_reset_addr_err", bus.addr_err, 0);

        // One beat tagged with a wrong return address.
        run_read(32'h0000_7008, {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                                 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000},
                 0, 1, 16'h001F, 16'h0002, 32'h0000_7000);
        check("raddr_addr_err", bus.addr_err, line_t'(CHK_EN));
        step();
        step();
        check("raddr_addr_err_sticky", bus.addr_err, line_t'(CHK_EN));
        #2 rst = 1'b1;
        #1;
        check("raddr_err_cleared_by_reset", bus.addr_err, 0);
        step();
        rst = 1'b0;
        step();

        check("cmd_queue_drained",   q_cmd.size(),   0);
        check("wbeat_queue_drained", q_wbeat.size(), 0);
        check("resp_queue_drained",  q_resp.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
